// File: rtl/id_issue_ctrl_if.sv
// IF -> ID -> EX handshake bundle for the ID issue controller.
// The slave side is the controller; the master side is whoever drives IF/EX.
interface id_issue_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  if_valid;
   logic [DATA_WIDTH-1:0] if_instr;
   logic [DATA_WIDTH-1:0] if_pc;
   logic                  id_ready;
   logic                  ex_ready;
   logic                  ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  flush;
   logic                  id_valid;
   logic [DATA_WIDTH-1:0] id_instr;
   logic [DATA_WIDTH-1:0] id_pc;
   logic [2:0]            imm_type;
   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic [REG_ADDR_W-1:0] rd;
   logic                  illegal;
   logic [CNT_W-1:0]      stall_cnt;

   modport slave (
      input  if_valid, if_instr, if_pc, ex_ready, ex_mem_read, ex_rd, flush,
      output id_ready, id_valid, id_instr, id_pc, imm_type, rs1, rs2, rd, illegal, stall_cnt
   );

   modport master (
      output if_valid, if_instr, if_pc, ex_ready, ex_mem_read, ex_rd, flush,
      input  id_ready, id_valid, id_instr, id_pc, imm_type, rs1, rs2, rd, illegal, stall_cnt
   );
endinterface

// File: rtl/id_issue_ctrl.sv
// ID-stage issue controller: one-entry IF/ID holding register with opcode decode,
// load-use hazard bubble, EX flush and a saturating stall counter.
module id_issue_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   id_issue_ctrl_if.slave bus
);
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic                  full, hazard, id_valid, issue, id_ready, accept;
   logic                  uses_rs1, uses_rs2, bad_op;
   logic [2:0]            imm_type;
   logic [REG_ADDR_W-1:0] rs1, rs2, rd;

   assign full = (state_q == FULL);
   assign rs1  = instr_q[15 +: REG_ADDR_W];
   assign rs2  = instr_q[20 +: REG_ADDR_W];
   assign rd   = instr_q[7  +: REG_ADDR_W];

   // R-type shares the I select: ImmGe output is simply ignored downstream.
   always_comb begin
      imm_type = IMM_I;
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      bad_op   = 1'b0;
      case (instr_q[6:0])
         7'b0000011, 7'b0010011, 7'b1100111: imm_type = IMM_I;
         7'b0100011: begin imm_type = IMM_S; uses_rs2 = 1'b1; end
         7'b1100011: begin imm_type = IMM_B; uses_rs2 = 1'b1; end
         7'b0110111, 7'b0010111: begin imm_type = IMM_U; uses_rs1 = 1'b0; end
         7'b1101111: begin imm_type = IMM_J; uses_rs1 = 1'b0; end
         7'b0110011: uses_rs2 = 1'b1;
         default:    bad_op   = 1'b1;
      endcase
   end

   assign hazard   = full && bus.ex_mem_read && (bus.ex_rd != '0) &&
                     ((uses_rs1 && (rs1 == bus.ex_rd)) || (uses_rs2 && (rs2 == bus.ex_rd)));
   assign id_valid = full && !hazard && !bus.flush;
   assign issue    = id_valid && bus.ex_ready;
   assign id_ready = !full || issue;
   assign accept   = bus.if_valid && id_ready && !bus.flush;

   // Flush outranks everything; accept covers the issue+refill back-to-back case.
   always_comb begin
      state_d = state_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         state_d = EMPTY;
      end else if (accept) begin
         state_d = FULL;
         instr_d = bus.if_instr;
         pc_d    = bus.if_pc;
      end else if (issue) begin
         state_d = EMPTY;
      end
      if (full && !issue && !bus.flush && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= EMPTY;
         instr_q <= '0;
         pc_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.id_ready  = id_ready;
   assign bus.id_valid  = id_valid;
   assign bus.id_instr  = instr_q;
   assign bus.id_pc     = pc_q;
   assign bus.imm_type  = imm_type;
   assign bus.rs1       = rs1;
   assign bus.rs2       = rs2;
   assign bus.rd        = rd;
   assign bus.illegal   = id_valid && bad_op;
   assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed scenarios plus a randomized run against a
// one-slot behavioural model of the IF/ID register.
module tb_id_issue_ctrl;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_issue_ctrl_if #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();
   id_issue_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_pass = 0;

   // Model: the register is a slot that is either empty or holds one instruction.
   bit          m_full = 1'b0;
   logic [31:0] m_instr = '0;
   logic [31:0] m_pc = '0;
   int          m_cnt = 0;

   // 0 I, 1 S, 2 B, 3 U, 4 J, 5 R, 6 unsupported
   function automatic int cls(input logic [31:0] ins);
      case (ins[6:0])
         7'h03, 7'h13, 7'h67: return 0;
         7'h23:               return 1;
         7'h63:               return 2;
         7'h37, 7'h17:        return 3;
         7'h6f:               return 4;
         7'h33:               return 5;
         default:             return 6;
      endcase
   endfunction

   function automatic bit m_hazard();
      int c;
      bit r1, r2;
      c = cls(m_instr);
      r1 = (c != 3) && (c != 4) && (m_instr[19:15] == bus.ex_rd);
      r2 = (c == 1 || c == 2 || c == 5) && (m_instr[24:20] == bus.ex_rd);
      return m_full && bus.ex_mem_read && (bus.ex_rd != 0) && (r1 || r2);
   endfunction

   function automatic bit e_valid();
      return m_full && !m_hazard() && !bus.flush;
   endfunction

   function automatic bit e_ready();
      return !m_full || (e_valid() && bus.ex_ready);
   endfunction

   task automatic tick();
      bit iss, acc;
      iss = e_valid() && bus.ex_ready;
      acc = bus.if_valid && e_ready() && !bus.flush;
      if (!rst_n) begin
         m_full = 0; m_instr = '0; m_pc = '0; m_cnt = 0;
      end else begin
         if (m_full && !iss && !bus.flush && m_cnt < CMAX) m_cnt++;
         if (bus.flush) m_full = 0;
         else if (acc) begin m_full = 1; m_instr = bus.if_instr; m_pc = bus.if_pc; end
         else if (iss) m_full = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.if_valid = 0; bus.if_instr = '0; bus.if_pc = '0;
      bus.ex_ready = 1; bus.ex_mem_read = 0; bus.ex_rd = '0; bus.flush = 0;
   endtask

   task automatic reset_dut();
      idle();
      rst_n = 0;
      tick();
      rst_n = 1;
   endtask

   task automatic load(input logic [31:0] ins, input logic [31:0] pc);
      bus.if_valid = 1; bus.if_instr = ins; bus.if_pc = pc;
      tick();
      bus.if_valid = 0;
   endtask

   task automatic test_reset();
      reset_dut();
      n_chk++; if (bus.id_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", bus.id_valid); else n_pass++;
      n_chk++; if (bus.id_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", bus.id_ready); else n_pass++;
      n_chk++; if (bus.imm_type !== 3'b000) $display("FAIL rst_imm got %b want 000", bus.imm_type); else n_pass++;
      n_chk++; if (bus.illegal !== 1'b0) $display("FAIL rst_illegal got %b want 0", bus.illegal); else n_pass++;
      n_chk++; if (bus.stall_cnt !== '0) $display("FAIL rst_cnt got %0d want 0", bus.stall_cnt); else n_pass++;
      n_chk++; if (bus.id_instr !== '0 || bus.id_pc !== '0) $display("FAIL rst_regs got %h/%h want 0/0", bus.id_instr, bus.id_pc); else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] prog [5];
      prog[0] = 32'h00100093; prog[1] = 32'h0020a023; prog[2] = 32'h00208063;
      prog[3] = 32'h000012b7; prog[4] = 32'h0000006f;
      reset_dut();
      for (int k = 0; k < 5; k++) begin
         bus.if_valid = 1; bus.if_instr = prog[k]; bus.if_pc = 32'h100 + 4 * k;
         tick();
         n_chk++; if (bus.id_valid !== 1'b1 || bus.id_ready !== 1'b1) $display("FAIL stream_vr%0d got %b%b want 11", k, bus.id_valid, bus.id_ready); else n_pass++;
         n_chk++; if (bus.imm_type !== k[2:0]) $display("FAIL stream_imm%0d got %0d want %0d", k, bus.imm_type, k); else n_pass++;
         n_chk++; if (bus.id_instr !== prog[k] || bus.id_pc !== 32'h100 + 4 * k) $display("FAIL stream_data%0d got %h want %h", k, bus.id_instr, prog[k]); else n_pass++;
      end
      bus.if_valid = 0;
      tick();
      n_chk++; if (bus.id_valid !== 1'b0 || bus.stall_cnt !== '0) $display("FAIL stream_end got v=%b cnt=%0d want v=0 cnt=0", bus.id_valid, bus.stall_cnt); else n_pass++;
   endtask

   task automatic test_load_use();
      reset_dut();
      load(32'h00728333, 32'h200);
      bus.ex_mem_read = 1; bus.ex_rd = 5; #1;
      n_chk++; if (bus.id_valid !== 1'b0 || bus.id_ready !== 1'b0) $display("FAIL lu_bubble got v=%b r=%b want 0 0", bus.id_valid, bus.id_ready); else n_pass++;
      tick();
      bus.ex_mem_read = 0; #1;
      n_chk++; if (bus.id_valid !== 1'b1) $display("FAIL lu_release got %b want 1", bus.id_valid); else n_pass++;
      tick();
      n_chk++; if (bus.id_valid !== 1'b0 || bus.stall_cnt !== 4'd1) $display("FAIL lu_after got v=%b cnt=%0d want v=0 cnt=1", bus.id_valid, bus.stall_cnt); else n_pass++;
      reset_dut();
      load(32'h00728333, 32'h204);
      bus.ex_mem_read = 1; bus.ex_rd = 0; #1;
      n_chk++; if (bus.id_valid !== 1'b1) $display("FAIL lu_x0 got %b want 1", bus.id_valid); else n_pass++;
      tick();
      reset_dut();
      load(32'h000282b7, 32'h208);
      bus.ex_mem_read = 1; bus.ex_rd = 5; #1;
      n_chk++; if (bus.id_valid !== 1'b1) $display("FAIL lu_lui got %b want 1", bus.id_valid); else n_pass++;
      tick();
      n_chk++; if (bus.stall_cnt !== '0) $display("FAIL lu_lui_cnt got %0d want 0", bus.stall_cnt); else n_pass++;
      idle();
   endtask

   task automatic test_backpressure();
      reset_dut();
      load(32'h00a00513, 32'h300);
      bus.ex_ready = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++; if (bus.id_valid !== 1'b1 || bus.id_ready !== 1'b0 || bus.id_instr !== 32'h00a00513)
            $display("FAIL bp_hold%0d got v=%b r=%b i=%h want 1 0 00a00513", k, bus.id_valid, bus.id_ready, bus.id_instr); else n_pass++;
         tick();
      end
      n_chk++; if (bus.stall_cnt !== 4'd3) $display("FAIL bp_cnt got %0d want 3", bus.stall_cnt); else n_pass++;
      bus.ex_ready = 1; bus.if_valid = 1; bus.if_instr = 32'h0020a023; bus.if_pc = 32'h304; #1;
      n_chk++; if (bus.id_ready !== 1'b1) $display("FAIL bp_ready got %b want 1", bus.id_ready); else n_pass++;
      tick();
      n_chk++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h0020a023 || bus.stall_cnt !== 4'd3)
         $display("FAIL bp_b2b got v=%b i=%h cnt=%0d want 1 0020a023 3", bus.id_valid, bus.id_instr, bus.stall_cnt); else n_pass++;
      idle();
   endtask

   task automatic test_flush();
      reset_dut();
      load(32'h00100093, 32'h400);
      bus.flush = 1; bus.if_valid = 1; bus.if_instr = 32'h0020a023; bus.if_pc = 32'h404; #1;
      n_chk++; if (bus.id_valid !== 1'b0) $display("FAIL fl_comb got %b want 0", bus.id_valid); else n_pass++;
      tick();
      idle();
      #1;
      n_chk++; if (bus.id_valid !== 1'b0 || bus.id_ready !== 1'b1 || bus.stall_cnt !== '0)
         $display("FAIL fl_empty got v=%b r=%b cnt=%0d want 0 1 0", bus.id_valid, bus.id_ready, bus.stall_cnt); else n_pass++;
      load(32'h00728333, 32'h408);
      bus.ex_mem_read = 1; bus.ex_rd = 7; bus.flush = 1;
      tick();
      idle();
      #1;
      n_chk++; if (bus.id_valid !== 1'b0 || bus.id_ready !== 1'b1) $display("FAIL fl_hazard got v=%b r=%b want 0 1", bus.id_valid, bus.id_ready); else n_pass++;
   endtask

   task automatic test_illegal_sat();
      reset_dut();
      load(32'h0000007f, 32'h500);
      bus.ex_ready = 0; #1;
      n_chk++; if (bus.illegal !== 1'b1 || bus.imm_type !== 3'b000 || bus.id_valid !== 1'b1)
         $display("FAIL ill got ill=%b imm=%b v=%b want 1 000 1", bus.illegal, bus.imm_type, bus.id_valid); else n_pass++;
      repeat (20) tick();
      n_chk++; if (bus.stall_cnt !== 4'd15) $display("FAIL sat got %0d want 15", bus.stall_cnt); else n_pass++;
      idle();
      tick();
   endtask

   task automatic test_reset_mid();
      reset_dut();
      load(32'h00100093, 32'h600);
      bus.ex_ready = 0;
      tick();
      rst_n = 0;
      tick();
      n_chk++; if (bus.id_valid !== 1'b0 || bus.stall_cnt !== '0 || bus.id_ready !== 1'b1)
         $display("FAIL rmid got v=%b cnt=%0d r=%b want 0 0 1", bus.id_valid, bus.stall_cnt, bus.id_ready); else n_pass++;
      rst_n = 1; bus.ex_ready = 1;
      load(32'h0020a023, 32'h604);
      n_chk++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 32'h0020a023 || bus.id_pc !== 32'h604)
         $display("FAIL rmid_acc got v=%b i=%h want 1 0020a023", bus.id_valid, bus.id_instr); else n_pass++;
   endtask

   task automatic test_random();
      logic [6:0]  ops [9];
      logic [31:0] r;
      int errs;
      ops[0] = 7'h03; ops[1] = 7'h13; ops[2] = 7'h67; ops[3] = 7'h23; ops[4] = 7'h63;
      ops[5] = 7'h37; ops[6] = 7'h6f; ops[7] = 7'h33; ops[8] = 7'h7f;
      reset_dut();
      errs = 0;
      for (int c = 0; c < 600; c++) begin
         r = $urandom();
         r[19:15] = 5'($urandom_range(0, 3));
         r[24:20] = 5'($urandom_range(0, 3));
         r[6:0] = ops[$urandom_range(0, 8)];
         bus.if_valid = ($urandom_range(0, 3) != 0);
         bus.if_instr = r;
         bus.if_pc = $urandom();
         bus.ex_ready = ($urandom_range(0, 3) != 0);
         bus.ex_mem_read = $urandom_range(0, 1);
         bus.ex_rd = 5'($urandom_range(0, 3));
         bus.flush = ($urandom_range(0, 11) == 0);
         rst_n = ($urandom_range(0, 79) != 0);
         #1;
         n_chk++;
         if (bus.id_valid !== e_valid() || bus.id_ready !== e_ready() || bus.stall_cnt !== CW'(m_cnt) ||
             bus.illegal !== (e_valid() && cls(m_instr) == 6)) begin
            if (errs < 10) $display("FAIL rnd_ctl c=%0d got v=%b r=%b cnt=%0d ill=%b want v=%b r=%b cnt=%0d", c,
               bus.id_valid, bus.id_ready, bus.stall_cnt, bus.illegal, e_valid(), e_ready(), m_cnt);
            errs++;
         end else n_pass++;
         if (m_full) begin
            n_chk++;
            if (bus.id_instr !== m_instr || bus.id_pc !== m_pc || bus.rs1 !== m_instr[19:15] ||
                bus.rs2 !== m_instr[24:20] || bus.rd !== m_instr[11:7] ||
                bus.imm_type !== ((cls(m_instr) <= 4) ? 3'(cls(m_instr)) : 3'b000)) begin
               if (errs < 10) $display("FAIL rnd_data c=%0d got %h/%h imm=%0d want %h/%h", c,
                  bus.id_instr, bus.id_pc, bus.imm_type, m_instr, m_pc);
               errs++;
            end else n_pass++;
         end
         tick();
      end
      rst_n = 1;
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_stream();
      test_load_use();
      test_backpressure();
      test_flush();
      test_illegal_sat();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
